// File: rtl/io_map.sv
// rtl/io_map.sv - CPU bus decoder: internal RAM, boot ROM image, GPIO port window, ROM wait states.
// Optional input-change interrupt status register enabled by defining IO_IRQ_EN.
module io_map #(
    parameter int          RAM_ADDR_BITS = 15,
    parameter int          ROM_ADDR_BITS = 11,
    parameter logic [15:0] IO_BASE       = 16'h8400,
    parameter int          NUM_PORTS     = 4,
    parameter int          ROM_WAIT      = 0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [15:0]            addr,
    input  logic [7:0]             data_in,
    output logic [7:0]             data_out,
    input  logic                   read_enable,
    input  logic                   write_enable,
    output logic                   ready,
    output logic [8*NUM_PORTS-1:0] io_out,
    input  logic [8*NUM_PORTS-1:0] io_in,
    output logic                   irq
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

`ifdef IO_IRQ_EN
    localparam int STATUS_SLOTS = 1;
`else
    localparam int STATUS_SLOTS = 0;
`endif
    localparam int IO_SPAN = 2 * NUM_PORTS + STATUS_SLOTS;

    logic [0:0]                  state;
    logic [2:0]                  wait_cnt;
    logic [NUM_PORTS-1:0][7:0]   out_q;
    logic [NUM_PORTS-1:0][7:0]   sync1;
    logic [NUM_PORTS-1:0][7:0]   sync2;
    logic [7:0]                  ram [2**RAM_ADDR_BITS];

    logic [16:0] addr_x;
    logic [16:0] io_diff;
    logic [4:0]  io_off;
    logic        ram_hit;
    logic        rom_hit;
    logic        io_hit;
    logic [7:0]  rom_data;
    logic [7:0]  rd_byte;
    logic        write_req;

    assign addr_x    = {1'b0, addr};
    assign io_diff   = addr_x - {1'b0, IO_BASE};
    assign io_off    = io_diff[4:0];
    assign ram_hit   = addr_x < 17'(2**RAM_ADDR_BITS);
    assign rom_hit   = addr_x >= 17'(65536 - 2**ROM_ADDR_BITS);
    assign io_hit    = io_diff < 17'(IO_SPAN);
    assign write_req = reset_n && (state == IDLE) && write_enable;
    assign io_out    = out_q;

    // Boot image: each byte is its address low byte XOR 8'hC3.
    assign rom_data = addr[7:0] ^ 8'hC3;

`ifdef IO_IRQ_EN
    logic [NUM_PORTS-1:0][7:0] sync3;
    logic [NUM_PORTS-1:0]      status;
    logic [NUM_PORTS-1:0]      edge_seen;
    logic [NUM_PORTS-1:0]      clear_mask;
    logic                      status_hit;
    logic                      irq_q;

    assign status_hit = io_hit && (io_off == 5'(2 * NUM_PORTS));
    assign irq        = irq_q;

    always_comb begin
        edge_seen  = '0;
        clear_mask = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            edge_seen[k] = |(sync2[k] & ~sync3[k]);
        end
        if (write_req && status_hit) begin
            clear_mask = data_in[NUM_PORTS-1:0];
        end
    end

    // A fresh edge in the clear cycle keeps its bit set.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync3  <= '0;
            status <= '0;
            irq_q  <= 1'b0;
        end else begin
            sync3  <= sync2;
            status <= (status & ~clear_mask) | edge_seen;
            irq_q  <= |status;
        end
    end
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rd_byte = 8'hFF;
        if (ram_hit) begin
            rd_byte = ram[addr[RAM_ADDR_BITS-1:0]];
        end else if (rom_hit) begin
            rd_byte = rom_data;
        end else if (io_hit) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (io_off == 5'(2 * k)) begin
                    rd_byte = out_q[k];
                end else if (io_off == 5'(2 * k + 1)) begin
                    rd_byte = sync2[k];
                end
            end
`ifdef IO_IRQ_EN
            if (status_hit) begin
                rd_byte = 8'(status);
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (write_req && ram_hit) begin
            ram[addr[RAM_ADDR_BITS-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            wait_cnt <= 3'd0;
            ready    <= 1'b1;
            data_out <= 8'h00;
            out_q    <= '0;
            sync1    <= '0;
            sync2    <= '0;
        end else begin
            sync1 <= io_in;
            sync2 <= sync1;
            case (state)
                IDLE: begin
                    if (write_enable) begin
                        if (io_hit) begin
                            for (int k = 0; k < NUM_PORTS; k++) begin
                                if (io_off == 5'(2 * k)) begin
                                    out_q[k] <= data_in;
                                end
                            end
                        end
                    end else if (read_enable) begin
                        if (rom_hit && (ROM_WAIT > 0)) begin
                            state    <= WAIT;
                            wait_cnt <= 3'(ROM_WAIT - 1);
                            ready    <= 1'b0;
                        end else begin
                            data_out <= rd_byte;
                        end
                    end
                end
                default: begin
                    // The CPU holds addr stable, so the ROM byte is sampled on the last wait cycle.
                    if (wait_cnt == 3'd0) begin
                        data_out <= rd_byte;
                        ready    <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_map.sv
// tb/tb_io_map.sv - directed table-driven bench for io_map with ROM_WAIT=2.
module tb_io_map;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] addr;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        read_enable;
    logic        write_enable;
    logic        ready;
    logic [31:0] io_out;
    logic [31:0] io_in;
    logic        irq;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    io_map #(
        .RAM_ADDR_BITS(15),
        .ROM_ADDR_BITS(11),
        .IO_BASE      (16'h8400),
        .NUM_PORTS    (4),
        .ROM_WAIT     (2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .addr        (addr),
        .data_in     (data_in),
        .data_out    (data_out),
        .read_enable (read_enable),
        .write_enable(write_enable),
        .ready       (ready),
        .io_out      (io_out),
        .io_in       (io_in),
        .irq         (irq)
    );

    typedef struct packed {
        logic        we;
        logic        re;
        logic [15:0] a;
        logic [7:0]  d;
        logic [7:0]  exp_data;
        logic [31:0] exp_io;
    } vec_t;

    vec_t vt [22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic we, input logic re, input logic [15:0] a, input logic [7:0] d);
        write_enable = we;
        read_enable  = re;
        addr         = a;
        data_in      = d;
        cycle();
        write_enable = 1'b0;
        read_enable  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [7:0] status_idle;

`ifdef IO_IRQ_EN
        status_idle = 8'h00;
`else
        status_idle = 8'hFF;
`endif
        //               we    re    addr       din    data   io_out
        vt[0]  = '{1'b1, 1'b0, 16'h8400, 8'hA5, 8'h00, 32'h0000_00A5};
        vt[1]  = '{1'b0, 1'b1, 16'h8400, 8'h00, 8'hA5, 32'h0000_00A5};
        vt[2]  = '{1'b1, 1'b0, 16'h8402, 8'h11, 8'hA5, 32'h0000_11A5};
        vt[3]  = '{1'b1, 1'b0, 16'h8406, 8'h7E, 8'hA5, 32'h7E00_11A5};
        vt[4]  = '{1'b1, 1'b0, 16'h1234, 8'h5A, 8'hA5, 32'h7E00_11A5};
        vt[5]  = '{1'b0, 1'b1, 16'h1234, 8'h00, 8'h5A, 32'h7E00_11A5};
        vt[6]  = '{1'b0, 1'b1, 16'h9000, 8'h00, 8'hFF, 32'h7E00_11A5};
        vt[7]  = '{1'b1, 1'b0, 16'h0000, 8'h33, 8'hFF, 32'h7E00_11A5};
        vt[8]  = '{1'b0, 1'b1, 16'h0000, 8'h00, 8'h33, 32'h7E00_11A5};
        vt[9]  = '{1'b1, 1'b0, 16'h7FFF, 8'hC8, 8'h33, 32'h7E00_11A5};
        vt[10] = '{1'b0, 1'b1, 16'h7FFF, 8'h00, 8'hC8, 32'h7E00_11A5};
        vt[11] = '{1'b0, 1'b1, 16'h8000, 8'h00, 8'hFF, 32'h7E00_11A5};
        vt[12] = '{1'b0, 1'b1, 16'h83FF, 8'h00, 8'hFF, 32'h7E00_11A5};
        vt[13] = '{1'b0, 1'b1, 16'h8406, 8'h00, 8'h7E, 32'h7E00_11A5};
        vt[14] = '{1'b0, 1'b1, 16'h8408, 8'h00, status_idle, 32'h7E00_11A5};
        vt[15] = '{1'b0, 1'b1, 16'h8409, 8'h00, 8'hFF, 32'h7E00_11A5};
        vt[16] = '{1'b1, 1'b1, 16'h8400, 8'h99, 8'hFF, 32'h7E00_1199};
        vt[17] = '{1'b0, 1'b1, 16'h8400, 8'h00, 8'h99, 32'h7E00_1199};
        vt[18] = '{1'b1, 1'b0, 16'h9000, 8'h44, 8'h99, 32'h7E00_1199};
        vt[19] = '{1'b1, 1'b0, 16'hF900, 8'h12, 8'h99, 32'h7E00_1199};
        vt[20] = '{1'b0, 1'b1, 16'hF7FF, 8'h00, 8'hFF, 32'h7E00_1199};
        vt[21] = '{1'b0, 1'b0, 16'h1234, 8'h00, 8'hFF, 32'h7E00_1199};

        reset_n      = 1'b0;
        addr         = 16'h0000;
        data_in      = 8'h00;
        read_enable  = 1'b0;
        write_enable = 1'b0;
        io_in        = 32'h0;
        cycle();
        cycle();
        check("reset_io_out", io_out, 32'h0);
        check("reset_data_out", 32'(data_out), 32'h00);
        check("reset_ready", 32'(ready), 32'h1);
        check("reset_irq", 32'(irq), 32'h0);
        reset_n = 1'b1;
        cycle();

        for (int i = 0; i < 22; i++) begin
            bus(vt[i].we, vt[i].re, vt[i].a, vt[i].d);
            check($sformatf("vec%0d_data", i), 32'(data_out), 32'(vt[i].exp_data));
            check($sformatf("vec%0d_ready", i), 32'(ready), 32'h1);
            check($sformatf("vec%0d_io", i), io_out, vt[i].exp_io);
        end

        // Synchronised input port and ignored write to it.
        io_in = 32'h0000_3C00;
        cycle();
        cycle();
        bus(1'b0, 1'b1, 16'h8403, 8'h00);
        check("in_port1_read", 32'(data_out), 32'h3C);
        bus(1'b1, 1'b0, 16'h8403, 8'h55);
        check("in_port1_write_ignored", io_out, 32'h7E00_1199);
        bus(1'b0, 1'b1, 16'h8403, 8'h00);
        check("in_port1_reread", 32'(data_out), 32'h3C);

        // ROM read with two wait states.
        addr        = 16'hF800;
        read_enable = 1'b1;
        cycle();
        check("rom_wait_cycle1", 32'(ready), 32'h0);
        cycle();
        check("rom_wait_cycle2", 32'(ready), 32'h0);
        cycle();
        check("rom_done_ready", 32'(ready), 32'h1);
        check("rom_f800_data", 32'(data_out), 32'hC3);
        read_enable = 1'b0;

        addr        = 16'hFFFF;
        read_enable = 1'b1;
        n = 0;
        do begin
            cycle();
            n++;
        end while (ready !== 1'b1 && n < 10);
        read_enable = 1'b0;
        check("rom_ffff_latency", 32'(n), 32'd3);
        check("rom_ffff_data", 32'(data_out), 32'h3C);

        // Reset while waiting aborts the access.
        addr        = 16'hF800;
        read_enable = 1'b1;
        cycle();
        check("abort_wait_entered", 32'(ready), 32'h0);
        reset_n     = 1'b0;
        read_enable = 1'b0;
        cycle();
        check("abort_ready", 32'(ready), 32'h1);
        check("abort_data", 32'(data_out), 32'h00);
        check("abort_io_out", io_out, 32'h0);
        reset_n = 1'b1;
        cycle();
        cycle();
        check("abort_no_late_data", 32'(data_out), 32'h00);
        check("abort_ready_hold", 32'(ready), 32'h1);

`ifdef IO_IRQ_EN
        io_in = 32'h0;
        repeat (4) cycle();
        bus(1'b1, 1'b0, 16'h8408, 8'hFF);
        repeat (2) cycle();
        check("irq_cleared_start", 32'(irq), 32'h0);

        io_in = 32'h0000_0001;
        n = 0;
        do begin
            cycle();
            n++;
        end while (irq !== 1'b1 && n < 8);
        check("irq_rise", 32'(irq), 32'h1);
        check("irq_latency_le4", 32'(n <= 4), 32'h1);
        bus(1'b0, 1'b1, 16'h8408, 8'h00);
        check("irq_status_read", 32'(data_out), 32'h01);
        bus(1'b1, 1'b0, 16'h8408, 8'h01);
        cycle();
        check("irq_after_clear", 32'(irq), 32'h0);
        bus(1'b0, 1'b1, 16'h8408, 8'h00);
        check("irq_status_clear", 32'(data_out), 32'h00);

        io_in = 32'h0000_0101;
        repeat (4) cycle();
        io_in = 32'h0000_0001;
        repeat (4) cycle();
        io_in = 32'h0000_0101;
        cycle();
        cycle();
        bus(1'b1, 1'b0, 16'h8408, 8'h02);
        bus(1'b0, 1'b1, 16'h8408, 8'h00);
        check("irq_edge_beats_clear", 32'(data_out), 32'h02);
        check("irq_still_set", 32'(irq), 32'h1);
`else
        io_in = 32'h0000_0001;
        repeat (6) cycle();
        check("irq_tied_low", 32'(irq), 32'h0);
        bus(1'b0, 1'b1, 16'h8408, 8'h00);
        check("status_unmapped", 32'(data_out), 32'hFF);
        check("status_unmapped_ready", 32'(ready), 32'h1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
